// File: rtl/span_screensaver_engine.sv
// Column-span screensaver renderer: a runtime-loaded span table per column, a horizontal
// scroll offset and a writable phase-cycled palette, producing one registered RGB565 pixel per clock.
module span_screensaver_engine #(
  parameter int SCREEN_W   = 96,
  parameter int SCREEN_H   = 64,
  parameter int XW         = 8,
  parameter int YW         = 7,
  parameter int NUM_SPANS  = 2,
  parameter int NUM_PHASES = 2,
  parameter int SECT1_END  = 30,
  parameter int SECT2_END  = 65,
  parameter int BORDER     = 2
) (
  input  logic          clk12p5mhz_clk,
  input  logic          reset,
  input  logic          tick,
  input  logic          scroll_en,
  input  logic [XW-1:0] coordinate_x,
  input  logic [YW-1:0] coordinate_y,
  input  logic          wr_en,
  input  logic [XW-1:0] wr_col,
  input  logic [1:0]    wr_span,
  input  logic [YW-1:0] wr_lower,
  input  logic [YW-1:0] wr_upper,
  input  logic          pal_we,
  input  logic [3:0]    pal_addr,
  input  logic [15:0]   pal_data,
  output logic          wr_ready,
  output logic [1:0]    phase,
  output logic [15:0]   volume_color
);

  localparam int             IW       = $clog2(SCREEN_W);
  localparam int             SW       = (NUM_SPANS > 1) ? $clog2(NUM_SPANS) : 1;
  localparam logic [XW-1:0]  W_X      = XW'(SCREEN_W);
  localparam logic [XW-1:0]  LAST_COL = XW'(SCREEN_W - 1);
  localparam logic [XW:0]    W_EXT    = (XW+1)'(SCREEN_W);
  localparam logic [1:0]     LAST_PH  = 2'(NUM_PHASES - 1);
  localparam logic [2:0]     NSP      = 3'(NUM_SPANS);
  localparam logic [YW-1:0]  Y_LO     = YW'(BORDER);
  localparam logic [YW-1:0]  Y_HI     = YW'(SCREEN_H - BORDER);
  localparam logic [XW-1:0]  S1       = XW'(SECT1_END);
  localparam logic [XW-1:0]  S2       = XW'(SECT2_END);

  typedef enum logic {CLEAR, RUN} state_t;

  // Palette index is {phase, section}; phases 2..3 mirror phase 0, section 3 is unused.
  function automatic logic [15:0][15:0] pal_init();
    logic [15:0][15:0] p;
    logic [3:0] a;
    for (int i = 0; i < 16; i++) begin
      a = 4'(i);
      p[i] = 16'h0000;
      if (a[3:2] == 2'd1) begin
        case (a[1:0])
          2'd0: p[i] = 16'hF81F;
          2'd1: p[i] = 16'h07FF;
          2'd2: p[i] = 16'hFFFF;
          default: p[i] = 16'h0000;
        endcase
      end else begin
        case (a[1:0])
          2'd0: p[i] = 16'hF800;
          2'd1: p[i] = 16'h07E0;
          2'd2: p[i] = 16'h001F;
          default: p[i] = 16'h0000;
        endcase
      end
    end
    return p;
  endfunction

  state_t            state_q, state_d;
  logic [XW-1:0]     col_cnt_q, col_cnt_d;
  logic [XW-1:0]     scroll_q, scroll_d;
  logic [1:0]        phase_q, phase_d;
  logic [15:0]       color_q, color_d;
  logic [15:0][15:0] pal_q, pal_d;
  logic [YW-1:0]     lower_q [SCREEN_W][NUM_SPANS];
  logic [YW-1:0]     lower_d [SCREEN_W][NUM_SPANS];
  logic [YW-1:0]     upper_q [SCREEN_W][NUM_SPANS];
  logic [YW-1:0]     upper_d [SCREEN_W][NUM_SPANS];

  logic [XW:0]       col_sum;
  logic [XW-1:0]     look_col;
  logic              hit;
  logic              visible;
  logic [1:0]        sect;

  // Control FSM and span-table updates
  always_comb begin
    state_d   = state_q;
    col_cnt_d = col_cnt_q;
    lower_d   = lower_q;
    upper_d   = upper_q;
    if (state_q == CLEAR) begin
      for (int s = 0; s < NUM_SPANS; s++) begin
        lower_d[col_cnt_q[IW-1:0]][s] = '1;
        upper_d[col_cnt_q[IW-1:0]][s] = '0;
      end
      if (col_cnt_q == LAST_COL) state_d = RUN;
      else                       col_cnt_d = col_cnt_q + 1'b1;
    end else if (wr_en && (wr_col < W_X) && ({1'b0, wr_span} < NSP)) begin
      lower_d[wr_col[IW-1:0]][wr_span[SW-1:0]] = wr_lower;
      upper_d[wr_col[IW-1:0]][wr_span[SW-1:0]] = wr_upper;
    end
  end

  always_comb begin
    scroll_d = scroll_q;
    phase_d  = phase_q;
    pal_d    = pal_q;
    if (tick) begin
      phase_d = (phase_q == LAST_PH) ? 2'd0 : phase_q + 2'd1;
      if (scroll_en) scroll_d = (scroll_q == LAST_COL) ? '0 : scroll_q + 1'b1;
    end
    if (pal_we) pal_d[pal_addr] = pal_data;
  end

  // Pixel lookup: content scrolls, colour sections are tied to the screen column
  always_comb begin
    col_sum = {1'b0, coordinate_x} + {1'b0, scroll_q};
    if (col_sum >= W_EXT) col_sum = col_sum - W_EXT;
    look_col = col_sum[XW-1:0];
    hit = 1'b0;
    if (look_col < W_X) begin
      for (int s = 0; s < NUM_SPANS; s++) begin
        if ((lower_q[look_col[IW-1:0]][s] <= upper_q[look_col[IW-1:0]][s]) &&
            (coordinate_y >= lower_q[look_col[IW-1:0]][s]) &&
            (coordinate_y <= upper_q[look_col[IW-1:0]][s]))
          hit = 1'b1;
      end
    end
    if (coordinate_x <= S1)      sect = 2'd0;
    else if (coordinate_x <= S2) sect = 2'd1;
    else                         sect = 2'd2;
    visible = (state_q == RUN) && (coordinate_x < W_X) &&
              (coordinate_y >= Y_LO) && (coordinate_y < Y_HI);
    color_d = (visible && hit) ? pal_q[{phase_q, sect}] : 16'h0000;
  end

  always_ff @(posedge clk12p5mhz_clk) begin
    if (reset) begin
      state_q   <= CLEAR;
      col_cnt_q <= '0;
      scroll_q  <= '0;
      phase_q   <= 2'd0;
      color_q   <= 16'h0000;
      pal_q     <= pal_init();
    end else begin
      state_q   <= state_d;
      col_cnt_q <= col_cnt_d;
      scroll_q  <= scroll_d;
      phase_q   <= phase_d;
      color_q   <= color_d;
      pal_q     <= pal_d;
    end
  end

  // Table contents need no reset: CLEAR rewrites every column after reset
  always_ff @(posedge clk12p5mhz_clk) begin
    lower_q <= lower_d;
    upper_q <= upper_d;
  end

  assign wr_ready     = (state_q == RUN);
  assign phase        = phase_q;
  assign volume_color = color_q;

endmodule

// File: tb/tb_span_screensaver_engine.sv
// Directed bench for span_screensaver_engine: clear timing, span hits, palette phases,
// scroll wrap, borders, dropped writes, palette writes and reset mid-run.
module tb_span_screensaver_engine;

  logic        clk = 1'b0;
  logic        reset;
  logic        tick, scroll_en;
  logic [7:0]  coordinate_x;
  logic [6:0]  coordinate_y;
  logic        wr_en;
  logic [7:0]  wr_col;
  logic [1:0]  wr_span;
  logic [6:0]  wr_lower, wr_upper;
  logic        pal_we;
  logic [3:0]  pal_addr;
  logic [15:0] pal_data;
  logic        wr_ready;
  logic [1:0]  phase;
  logic [15:0] volume_color;

  int checks = 0;
  int errors = 0;

  span_screensaver_engine dut (
    .clk12p5mhz_clk(clk), .reset(reset), .tick(tick), .scroll_en(scroll_en),
    .coordinate_x(coordinate_x), .coordinate_y(coordinate_y),
    .wr_en(wr_en), .wr_col(wr_col), .wr_span(wr_span),
    .wr_lower(wr_lower), .wr_upper(wr_upper),
    .pal_we(pal_we), .pal_addr(pal_addr), .pal_data(pal_data),
    .wr_ready(wr_ready), .phase(phase), .volume_color(volume_color)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wspan(input logic [7:0] c, input logic [1:0] s, input logic [6:0] lo, input logic [6:0] up);
    wr_en = 1'b1; wr_col = c; wr_span = s; wr_lower = lo; wr_upper = up;
    step();
    wr_en = 1'b0;
  endtask

  task automatic pix(input logic [7:0] x, input logic [6:0] y, input logic [15:0] exp, input string tag);
    coordinate_x = x; coordinate_y = y;
    step();
    chk(tag, {16'h0, volume_color}, {16'h0, exp});
  endtask

  task automatic do_tick();
    tick = 1'b1;
    step();
    tick = 1'b0;
  endtask

  task automatic wait_ready(input string tag, output int n);
    n = 0;
    while (!wr_ready && n < 200) begin
      step();
      n++;
    end
    chk(tag, wr_ready, 1'b1);
  endtask

  // Expected frame at phase 0, scroll 0, with the spans loaded before the sweep
  function automatic logic [15:0] exp_pix(input int x, input int y);
    logic h;
    logic [15:0] c;
    if (y < 2 || y >= 62) return 16'h0000;
    h = (x == 0  && y >= 10 && y <= 12) ||
        (x == 20 && (y == 37 || (y >= 42 && y <= 43))) ||
        (x == 40 && y >= 23 && y <= 25) ||
        (x == 70);
    c = (x <= 30) ? 16'hF800 : (x <= 65) ? 16'h07E0 : 16'h001F;
    return h ? c : 16'h0000;
  endfunction

  initial begin
    int n;
    int bad;
    reset = 1'b1; tick = 1'b0; scroll_en = 1'b0;
    coordinate_x = 8'd20; coordinate_y = 7'd37;
    wr_en = 1'b0; wr_col = '0; wr_span = '0; wr_lower = '0; wr_upper = '0;
    pal_we = 1'b0; pal_addr = '0; pal_data = '0;

    repeat (3) step();
    chk("rst_ready", wr_ready, 1'b0);
    chk("rst_color", volume_color, 16'h0000);
    chk("rst_phase", phase, 2'd0);

    reset = 1'b0;
    n = 0; bad = 0;
    while (!wr_ready && n < 200) begin
      step();
      n++;
      if (volume_color !== 16'h0000) bad++;
    end
    chk("clear_len", n, 96);
    chk("clear_color", bad, 0);
    pix(8'd20, 7'd37, 16'h0000, "post_clear");

    wspan(8'd20, 2'd0, 7'd37, 7'd37);
    wspan(8'd20, 2'd1, 7'd42, 7'd43);
    pix(8'd20, 7'd37, 16'hF800, "c20_y37");
    pix(8'd20, 7'd40, 16'h0000, "c20_y40");
    pix(8'd20, 7'd43, 16'hF800, "c20_y43");

    wspan(8'd40, 2'd0, 7'd23, 7'd25);
    pix(8'd40, 7'd24, 16'h07E0, "c40_ph0");
    do_tick();
    chk("phase_1", phase, 2'd1);
    pix(8'd40, 7'd24, 16'h07FF, "c40_ph1");
    do_tick();
    chk("phase_wrap", phase, 2'd0);
    pix(8'd40, 7'd24, 16'h07E0, "c40_ph0b");

    // 97 ticks so far leaves phase 1 and scroll 95
    wspan(8'd0, 2'd0, 7'd10, 7'd12);
    scroll_en = 1'b1;
    repeat (95) do_tick();
    chk("phase_97", phase, 2'd1);
    pix(8'd1, 7'd11, 16'hF81F, "scr95_x1");
    pix(8'd0, 7'd11, 16'h0000, "scr95_x0");
    do_tick();
    scroll_en = 1'b0;
    pix(8'd0, 7'd11, 16'hF800, "scr_wrap_x0");
    pix(8'd1, 7'd11, 16'h0000, "scr_wrap_x1");

    wspan(8'd70, 2'd0, 7'd0, 7'd63);
    pix(8'd70, 7'd0,  16'h0000, "bord_y0");
    pix(8'd70, 7'd1,  16'h0000, "bord_y1");
    pix(8'd70, 7'd2,  16'h001F, "bord_y2");
    pix(8'd70, 7'd61, 16'h001F, "bord_y61");
    pix(8'd70, 7'd62, 16'h0000, "bord_y62");
    pix(8'd70, 7'd63, 16'h0000, "bord_y63");
    pix(8'd96, 7'd30, 16'h0000, "x_off_screen");

    wspan(8'd96, 2'd0, 7'd5, 7'd60);
    wspan(8'd20, 2'd2, 7'd2, 7'd60);
    bad = 0;
    for (int x = 0; x < 96; x++) begin
      for (int y = 0; y < 64; y++) begin
        coordinate_x = 8'(x); coordinate_y = 7'(y);
        step();
        if (volume_color !== exp_pix(x, y)) bad++;
      end
    end
    chk("sweep_errs", bad, 0);

    pal_we = 1'b1; pal_addr = 4'b0010; pal_data = 16'h1234;
    step();
    pal_we = 1'b0;
    pix(8'd70, 7'd30, 16'h1234, "pal_write");

    // Tick and palette write on the same edge: that pixel sees old phase and entry
    coordinate_x = 8'd70; coordinate_y = 7'd30;
    tick = 1'b1; pal_we = 1'b1; pal_addr = 4'b0010; pal_data = 16'hABCD;
    step();
    tick = 1'b0; pal_we = 1'b0;
    chk("sim_old", volume_color, 16'h1234);
    step();
    chk("sim_new_ph1", volume_color, 16'hFFFF);
    do_tick();
    pix(8'd70, 7'd30, 16'hABCD, "sim_new_ph0");

    reset = 1'b1;
    step();
    reset = 1'b0;
    repeat (50) step();
    chk("mid_clear_ready", wr_ready, 1'b0);
    wspan(8'd20, 2'd0, 7'd37, 7'd37);
    wait_ready("reclear_done", n);
    chk("reclear_phase", phase, 2'd0);
    pix(8'd20, 7'd37, 16'h0000, "reclear_c20");
    pix(8'd70, 7'd30, 16'h0000, "reclear_c70");
    wspan(8'd70, 2'd0, 7'd0, 7'd63);
    pix(8'd70, 7'd30, 16'h001F, "pal_restored");
    pix(8'd0, 7'd30, 16'h0000, "scroll_reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
